ysyx_22040125_lsu_axi_bridge: RTL and testbench

//  Data-side bus bridge directly downstream of the MEM stage. Turns MEM's level-held

---
 rtl/ysyx_22040125_lsu_axi_bridge.sv | 166 ++++++++++++++++
 tb/tb_ysyx_22040125_lsu_axi_bridge.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040125_lsu_axi_bridge.sv
// Turns MEM's level-held load/store requests into single-beat AXI4-Lite transactions.
// A completion is held in HOLD until the pipeline advances. R/B waits are bounded by TIMEOUT_CYC.
`timescale 1ns/1ps
module ysyx_22040125_lsu_axi_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_r_en,
  input  logic        data_w_en,
  input  logic [31:0] data_r_addr,
  input  logic [31:0] data_w_addr,
  input  logic [2:0]  byte_off,
  input  logic [2:0]  arsize_code,
  input  logic [2:0]  awsize_code,
  input  logic [63:0] data_w,
  input  logic [7:0]  data_w_mask,
  input  logic        pipe_adv,
  output logic        data_r_valid,
  output logic        data_w_valid,
  output logic [63:0] rdata,
  output logic        bus_err,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  input  logic        rvalid,
  output logic        rready,
  input  logic [63:0] rdata_axi,
  input  logic [1:0]  rresp,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        wvalid,
  input  logic        wready,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp
);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW_W, WR_B, HOLD} state_t;

  state_t      state;
  logic [2:0]  off_q;
  logic [31:0] tmo_cnt;
  logic        timeout;

  function automatic logic [2:0] size_map(input logic [2:0] code);
    case (code)
      3'b100:  size_map = 3'd0;
      3'b010:  size_map = 3'd1;
      3'b001:  size_map = 3'd2;
      default: size_map = 3'd3;
    endcase
  endfunction

  // tmo_cnt counts waiting cycles already spent; abort on the TIMEOUT_CYC-th one.
  assign timeout = (TIMEOUT_CYC != 0) && (tmo_cnt == TIMEOUT_CYC - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      off_q        <= 3'd0;
      tmo_cnt      <= 32'd0;
      data_r_valid <= 1'b0;
      data_w_valid <= 1'b0;
      rdata        <= 64'd0;
      bus_err      <= 1'b0;
      arvalid      <= 1'b0;
      araddr       <= 32'd0;
      arsize       <= 3'd0;
      rready       <= 1'b0;
      awvalid      <= 1'b0;
      awaddr       <= 32'd0;
      awsize       <= 3'd0;
      wvalid       <= 1'b0;
      wdata        <= 64'd0;
      wstrb        <= 8'd0;
      bready       <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (data_r_en) begin
            araddr  <= data_r_addr;
            arsize  <= size_map(arsize_code);
            off_q   <= byte_off;
            arvalid <= 1'b1;
            state   <= RD_AR;
          end else if (data_w_en) begin
            awaddr  <= data_w_addr;
            awsize  <= size_map(awsize_code);
            off_q   <= byte_off;
            wdata   <= data_w << {byte_off, 3'b000};
            wstrb   <= data_w_mask;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= WR_AW_W;
          end
        end
        RD_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            tmo_cnt <= 32'd0;
            state   <= RD_R;
          end
        end
        RD_R: begin
          if (rvalid) begin
            rdata        <= rdata_axi >> {off_q, 3'b000};
            bus_err      <= (rresp != 2'b00);
            rready       <= 1'b0;
            data_r_valid <= 1'b1;
            state        <= HOLD;
          end else if (timeout) begin
            rdata        <= 64'd0;
            bus_err      <= 1'b1;
            rready       <= 1'b0;
            data_r_valid <= 1'b1;
            state        <= HOLD;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        WR_AW_W: begin
          // A dropped valid means that channel's handshake is already done.
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready) wvalid <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready  <= 1'b1;
            tmo_cnt <= 32'd0;
            state   <= WR_B;
          end
        end
        WR_B: begin
          if (bvalid) begin
            bus_err      <= (bresp != 2'b00);
            bready       <= 1'b0;
            data_w_valid <= 1'b1;
            state        <= HOLD;
          end else if (timeout) begin
            bus_err      <= 1'b1;
            bready       <= 1'b0;
            data_w_valid <= 1'b1;
            state        <= HOLD;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        HOLD: begin
          if (pipe_adv) begin
            data_r_valid <= 1'b0;
            data_w_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040125_lsu_axi_bridge.sv
// Scoreboard bench for the LSU AXI bridge: stimulus queues expectations, slave and
// completion monitors pop and compare when the DUT presents handshakes/completions.
`timescale 1ns/1ps
module tb_ysyx_22040125_lsu_axi_bridge;

  logic        clk, rst_n;
  logic        data_r_en, data_w_en, pipe_adv;
  logic [31:0] data_r_addr, data_w_addr;
  logic [2:0]  byte_off, arsize_code, awsize_code;
  logic [63:0] data_w;
  logic [7:0]  data_w_mask;
  logic        data_r_valid, data_w_valid, bus_err;
  logic [63:0] rdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] araddr, awaddr;
  logic [2:0]  arsize, awsize;
  logic [63:0] rdata_axi, wdata;
  logic [1:0]  rresp, bresp;
  logic [7:0]  wstrb;

  ysyx_22040125_lsu_axi_bridge #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_r_en(data_r_en), .data_w_en(data_w_en),
    .data_r_addr(data_r_addr), .data_w_addr(data_w_addr),
    .byte_off(byte_off), .arsize_code(arsize_code), .awsize_code(awsize_code),
    .data_w(data_w), .data_w_mask(data_w_mask), .pipe_adv(pipe_adv),
    .data_r_valid(data_r_valid), .data_w_valid(data_w_valid), .rdata(rdata), .bus_err(bus_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata_axi(rdata_axi), .rresp(rresp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  typedef struct { bit is_wr; logic [63:0] dat; bit err; int cyc; int hold; } cpl_t;
  typedef struct { logic [31:0] addr; logic [2:0] size; } ax_t;
  typedef struct { logic [63:0] dat; logic [7:0] strb; } w_t;

  cpl_t cpl_q[$];
  ax_t  ar_q[$];
  ax_t  aw_q[$];
  w_t   w_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int ar_dly, r_dly, aw_dly, w_dly, b_dly;
  logic [63:0] r_dat;
  logic [1:0]  r_rsp, b_rsp;
  bit r_flush, b_flush;
  int ar_tot = 0, aw_tot = 0, w_tot = 0, b_tot = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk)
    if (rst_n) assert (!(data_r_en && data_w_en)) else $error("bench drove both requests");

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input string act, input string exp);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %s, expected %s", name, act, exp);
  endtask

  // AXI read slave: programmable ARREADY and R latency.
  initial begin : rd_slave
    int ar_cnt, r_cnt;
    bit r_pend, r_done, ar_hs;
    ax_t e;
    arready = 0; rvalid = 0; rdata_axi = 0; rresp = 0;
    ar_cnt = 0; r_cnt = 0; r_pend = 0; r_done = 0; ar_hs = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || r_flush) begin
        arready = 0; rvalid = 0; ar_cnt = 0; r_cnt = 0;
        r_pend = 0; r_done = 0; ar_hs = 0; r_flush = 0;
      end else begin
        if (r_done) begin rvalid = 0; r_done = 0; end
        if (ar_hs) begin r_pend = 1; r_cnt = 0; ar_hs = 0; end
        if (r_pend) begin
          if (r_cnt >= r_dly) begin
            rvalid = 1; rdata_axi = r_dat; rresp = r_rsp; r_pend = 0;
          end else r_cnt++;
        end
        arready = arvalid && (ar_cnt >= ar_dly);
        if (arvalid && !arready) ar_cnt++;
      end
      @(negedge clk);
      if (rst_n && arvalid && arready) begin
        ar_hs = 1; ar_cnt = 0; ar_tot++;
        if (ar_q.size() == 0) fail_evt("ar_unexpected", "AR handshake", "none");
        else begin
          e = ar_q.pop_front();
          chk("araddr", araddr, e.addr);
          chk("arsize", arsize, e.size);
        end
      end
      if (rst_n && rvalid && rready) r_done = 1;
    end
  end

  // AXI write slave: independent AWREADY/WREADY delays, B after both handshakes.
  initial begin : wr_slave
    int aw_cnt, w_cnt, b_cnt;
    bit aw_seen, w_seen, b_pend, b_done;
    ax_t ea;
    w_t  ew;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; aw_seen = 0; w_seen = 0; b_pend = 0; b_done = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || b_flush) begin
        awready = 0; wready = 0; bvalid = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        aw_seen = 0; w_seen = 0; b_pend = 0; b_done = 0; b_flush = 0;
      end else begin
        if (b_done) begin bvalid = 0; b_done = 0; end
        if (aw_seen && w_seen) begin b_pend = 1; b_cnt = 0; aw_seen = 0; w_seen = 0; end
        if (b_pend) begin
          if (b_cnt >= b_dly) begin bvalid = 1; bresp = b_rsp; b_pend = 0; end
          else b_cnt++;
        end
        awready = awvalid && (aw_cnt >= aw_dly);
        if (awvalid && !awready) aw_cnt++;
        wready = wvalid && (w_cnt >= w_dly);
        if (wvalid && !wready) w_cnt++;
      end
      @(negedge clk);
      if (rst_n && awvalid && awready) begin
        aw_seen = 1; aw_cnt = 0; aw_tot++;
        if (aw_q.size() == 0) fail_evt("aw_unexpected", "AW handshake", "none");
        else begin
          ea = aw_q.pop_front();
          chk("awaddr", awaddr, ea.addr);
          chk("awsize", awsize, ea.size);
        end
      end
      if (rst_n && wvalid && wready) begin
        w_seen = 1; w_cnt = 0; w_tot++;
        if (w_q.size() == 0) fail_evt("w_unexpected", "W handshake", "none");
        else begin
          ew = w_q.pop_front();
          chk("wdata", wdata, ew.dat);
          chk("wstrb", wstrb, ew.strb);
        end
      end
      if (rst_n && bvalid && bready) begin b_done = 1; b_tot++; end
    end
  end

  // Completion monitor: type, data, error pulse, cycle, and hold length.
  initial begin : cpl_mon
    cpl_t cur;
    int run;
    bit v, prev;
    run = 0; prev = 0;
    cur.is_wr = 0; cur.dat = 0; cur.err = 0; cur.cyc = 0; cur.hold = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0; prev = 0;
      end else begin
        v = data_r_valid || data_w_valid;
        if (v && !prev) begin
          if (cpl_q.size() == 0) fail_evt("cpl_unexpected", "completion", "none");
          else begin
            cur = cpl_q.pop_front();
            chk("cpl_is_wr", {63'd0, data_w_valid}, {63'd0, cur.is_wr});
            if (!cur.is_wr) chk("rdata", rdata, cur.dat);
            chk("bus_err", {63'd0, bus_err}, {63'd0, cur.err});
            chk("cpl_cycle", cyc, cur.cyc);
          end
          run = 1;
        end else if (v) begin
          run++;
          if (bus_err) fail_evt("bus_err_len", "bus_err high after HOLD entry", "one-cycle pulse");
          if (!cur.is_wr && rdata !== cur.dat) fail_evt("rdata_stable", "rdata changed in HOLD", "stable");
        end else if (prev) begin
          chk("hold_len", run, cur.hold);
        end else if (bus_err) begin
          fail_evt("bus_err_spurious", "bus_err outside completion", "0");
        end
        prev = v;
      end
    end
  end

  task automatic wait_cpl(input int hold);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(data_r_valid || data_w_valid) && n < 40);
    if (!(data_r_valid || data_w_valid)) begin
      fail_evt("cpl_timeout", "no completion in 40 cycles", "completion");
      data_r_en = 0; data_w_en = 0;
      return;
    end
    pipe_adv = (hold == 1);
    for (int k = 2; k <= hold; k++) begin
      @(posedge clk); #1;
      pipe_adv = (k == hold);
    end
    data_r_en = 0; data_w_en = 0;
    @(posedge clk); #1;
    pipe_adv = 0;
  endtask

  task automatic do_rd(input logic [31:0] addr, input logic [2:0] off, input logic [2:0] code,
                       input logic [63:0] sdat, input logic [1:0] srsp, input int ard, input int rdl,
                       input logic [2:0] esize, input logic [63:0] edat, input bit eerr,
                       input int lat, input int hold);
    cpl_t c;
    ax_t a;
    @(posedge clk); #1;
    ar_dly = ard; r_dly = rdl; r_dat = sdat; r_rsp = srsp;
    data_r_en = 1; data_r_addr = addr; byte_off = off; arsize_code = code;
    a.addr = addr; a.size = esize; ar_q.push_back(a);
    c.is_wr = 0; c.dat = edat; c.err = eerr; c.cyc = cyc + lat; c.hold = hold;
    cpl_q.push_back(c);
    wait_cpl(hold);
  endtask

  task automatic do_wr(input logic [31:0] addr, input logic [2:0] off, input logic [2:0] code,
                       input logic [63:0] wd, input logic [7:0] mask,
                       input int awd, input int wdl, input int bd, input logic [1:0] brsp,
                       input logic [2:0] esize, input logic [63:0] ewd, input bit eerr,
                       input int lat, input int hold);
    cpl_t c;
    ax_t a;
    w_t w;
    @(posedge clk); #1;
    aw_dly = awd; w_dly = wdl; b_dly = bd; b_rsp = brsp;
    data_w_en = 1; data_w_addr = addr; byte_off = off; awsize_code = code;
    data_w = wd; data_w_mask = mask;
    a.addr = addr; a.size = esize; aw_q.push_back(a);
    w.dat = ewd; w.strb = mask; w_q.push_back(w);
    c.is_wr = 1; c.dat = 0; c.err = eerr; c.cyc = cyc + lat; c.hold = hold;
    cpl_q.push_back(c);
    wait_cpl(hold);
  endtask

  initial begin : stim
    int ar0, aw0, b0;
    ax_t a;
    w_t w;
    rst_n = 0; data_r_en = 0; data_w_en = 0; pipe_adv = 0;
    data_r_addr = 0; data_w_addr = 0; byte_off = 0; arsize_code = 0; awsize_code = 0;
    data_w = 0; data_w_mask = 0;
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
    r_dat = 0; r_rsp = 0; b_rsp = 0; r_flush = 0; b_flush = 0;

    repeat (3) @(posedge clk);
    #3;
    chk("rst_data_r_valid", {63'd0, data_r_valid}, 0);
    chk("rst_data_w_valid", {63'd0, data_w_valid}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bus_err", {63'd0, bus_err}, 0);
    chk("rst_arvalid", {63'd0, arvalid}, 0);
    chk("rst_awvalid", {63'd0, awvalid}, 0);
    chk("rst_wvalid", {63'd0, wvalid}, 0);
    chk("rst_rready", {63'd0, rready}, 0);
    chk("rst_bready", {63'd0, bready}, 0);
    chk("rst_araddr", {32'd0, araddr}, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wstrb", {56'd0, wstrb}, 0);
    rst_n = 1;

    // ld, zero-wait: completion in cycle 3
    do_rd(32'h8000_0000, 3'd0, 3'b000, 64'h1122_3344_5566_7788, 2'b00, 0, 0,
          3'd3, 64'h1122_3344_5566_7788, 0, 3, 1);
    // lb at byte 5
    do_rd(32'h8000_0105, 3'd5, 3'b100, 64'h0000_AB00_0000_0000, 2'b00, 0, 0,
          3'd0, 64'h0000_0000_0000_00AB, 0, 3, 1);
    // lh at byte 6 with ARREADY after 2 waits and R one cycle late
    do_rd(32'h8000_0206, 3'd6, 3'b010, 64'hCAFE_0000_0000_0000, 2'b00, 2, 1,
          3'd1, 64'h0000_0000_0000_CAFE, 0, 6, 1);

    // sh with awready three cycles after wready
    aw0 = aw_tot; b0 = b_tot;
    do_wr(32'h8000_1002, 3'd2, 3'b010, 64'h0000_0000_0000_BEEF, 8'h0C, 3, 0, 0, 2'b00,
          3'd1, 64'h0000_0000_BEEF_0000, 0, 6, 1);
    chk("sh_aw_count", aw_tot - aw0, 1);
    chk("sh_b_count", b_tot - b0, 1);
    // sw at byte 4, W late, B one cycle late with SLVERR
    do_wr(32'h8000_1004, 3'd4, 3'b001, 64'h0000_0000_1234_5678, 8'hF0, 0, 2, 1, 2'b10,
          3'd2, 64'h1234_5678_0000_0000, 1, 6, 1);
    // sd with AW and W in the same cycle, held two cycles
    do_wr(32'h8000_1008, 3'd0, 3'b000, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 0, 0, 0, 2'b00,
          3'd3, 64'hA5A5_5A5A_0F0F_F0F0, 0, 3, 2);

    // pipeline stalled four cycles: completion held five, only one AR
    ar0 = ar_tot;
    do_rd(32'h8000_0301, 3'd1, 3'b111, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 0,
          3'd3, 64'h0001_2345_6789_ABCD, 0, 3, 5);
    chk("stall_ar_count", ar_tot - ar0, 1);

    // R arrives too late: abort after four waits, then the late beat is ignored
    do_rd(32'h8000_0400, 3'd0, 3'b000, 64'hDEAD_BEEF_DEAD_BEEF, 2'b00, 0, 8,
          3'd3, 64'd0, 1, 6, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("late_r_rready", {63'd0, rready}, 0);
    chk("late_r_no_cpl", {63'd0, data_r_valid}, 0);
    r_flush = 1;
    repeat (2) @(posedge clk);

    // non-OKAY read response still returns data
    do_rd(32'h8000_0500, 3'd0, 3'b000, 64'h0000_0000_0000_0055, 2'b10, 0, 0,
          3'd3, 64'h0000_0000_0000_0055, 1, 3, 1);

    // reset asserted while waiting on B
    @(posedge clk); #1;
    aw_dly = 0; w_dly = 0; b_dly = 10; b_rsp = 0;
    data_w_en = 1; data_w_addr = 32'h8000_2000; byte_off = 0; awsize_code = 3'b000;
    data_w = 64'h1; data_w_mask = 8'hFF;
    a.addr = 32'h8000_2000; a.size = 3'd3; aw_q.push_back(a);
    w.dat = 64'h1; w.strb = 8'hFF; w_q.push_back(w);
    repeat (2) @(posedge clk);
    #3;
    chk("wr_b_bready", {63'd0, bready}, 1);
    rst_n = 0;
    #1;
    chk("arst_data_w_valid", {63'd0, data_w_valid}, 0);
    chk("arst_bready", {63'd0, bready}, 0);
    chk("arst_awvalid", {63'd0, awvalid}, 0);
    chk("arst_wvalid", {63'd0, wvalid}, 0);
    chk("arst_wdata", wdata, 0);
    data_w_en = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1;
    b_dly = 0;
    do_wr(32'h8000_2001, 3'd1, 3'b100, 64'h0000_0000_0000_007E, 8'h02, 0, 0, 0, 2'b00,
          3'd0, 64'h0000_0000_0000_7E00, 0, 3, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("cpl_q_empty", cpl_q.size(), 0);
    chk("ar_q_empty", ar_q.size(), 0);
    chk("aw_q_empty", aw_q.size(), 0);
    chk("w_q_empty", w_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
